unsharp_mask_stage: RTL and testbench
=====================================

// Module: unsharp_mask_stage
// PURPOSE
//  Downstream consumer of the gaussian pass-through delay line: takes the row/column-aligned original
//  pixel (pass_thru) and the 11x11 gaussian-blurred pixel for the same position, and outputs a
//  sharpened pixel: out = orig + amount*(orig - blur), clamped per channel. Frame-border pixels, where
//  the blur window is incomplete, pass through unchanged. Feeds the VGA/frame-buffer write path.
// PARAMETERS
//  WIDTH   640  active pixels per line
//  HEIGHT  480  active lines per frame
//  RADIUS  5    gaussian window radius; border band width in pixels/lines
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   asynchronous, active-high reset
//  pix_valid  in   1   input beat strobe (same strobe that shifts the pass-through line)
//  sof        in   1   start of frame; valid only with pix_valid; marks pixel (0,0)
//  pix_orig   in   24  aligned original pixel {R,G,B} 8b each
//  pix_blur   in   24  gaussian-blurred pixel {R,G,B}
//  amount     in   4   sharpen gain, unsigned Q2.2 (0..3.75)
//  pix_out    out  24  sharpened pixel {R,G,B}
//  out_valid  out  1   pix_out qualifier
//  out_border out  1   1 = pix_out is unmodified border pixel
// BEHAVIOUR
//  - Reset: pix_out=0, out_valid=0, out_border=0; col/row counters=0; amount_q=0; pipeline valids=0.
//  - Fixed 3-cycle pipeline, no stall: input beat at cycle N -> out_valid at N+3. Non-valid cycles
//    propagate as bubbles (out_valid=0; pix_out holds last value).
//  - Position counters: on pix_valid&sof -> col=0,row=0 for this beat; else on pix_valid col++;
//    col==WIDTH-1 -> col=0, row++; row==HEIGHT-1 at line end -> row=0. sof mid-frame resynchronises
//    immediately.
//  - amount_q latched from amount only on pix_valid&sof; used for whole frame (incl. sof beat).
//  - border = col<RADIUS | col>=WIDTH-RADIUS | row<RADIUS | row>=HEIGHT-RADIUS (evaluated on
//    the position of the input beat, carried through pipeline).
//  - Stage 1: per channel d = {1'b0,orig} - {1'b0,blur}, signed 9b (-255..255); register orig, border.
//  - Stage 2: p = d * amount_q, signed 14b; s = p >>> 2 (arithmetic, floor toward -inf).
//  - Stage 3: t = orig + s (signed 12b); clamp: t<0 -> 0, t>255 -> 255; border -> pix_out = orig.
//  - amount_q=0 -> pix_out == orig for every pixel.
//  - Reset mid-frame: all in-flight beats discarded; counters restart at 0 (next sof realigns).
// CONFIGURATION
//  UNSHARP_CORING_EN defined: adds port `coring in 8` (threshold). In stage 1, |d|<coring
//   forces d=0 (suppresses noise sharpening), compared per channel. coring=0 -> no effect.
//  Not defined: port absent, d used unmodified. Latency identical in both builds.
// TESTING
//  1. rst high mid-stream -> out_valid=0, pix_out=0 same cycle; no output until 3 cycles after
//     the next pix_valid.
//  2. amount=4'b0100 (1.0), interior pixel orig=0x808080, blur=0x707070 -> pix_out=0x909090,
//     out_valid exactly 3 cycles after input beat, out_border=0.
//  3. amount=4'b1111 (3.75), orig=0xF0F010, blur=0x10F0F0 -> pix_out=0xFFF000 (clamp high R, zero
//     diff G, clamp low B).
//  4. Full 640x480 frame with sof on first beat -> out_border=1 for exactly cols 0-4/635-639 and
//     rows 0-4/475-479; border pix_out == pix_orig regardless of blur.
//  5. amount changed from 4 to 8 mid-frame -> gain stays 1.0 until next sof beat, then 2.0.
//  6. UNSHARP_CORING_EN, coring=16: d=+10 -> out=orig; d=+20, amount=1.0 -> out=orig+20.
//     Gaps: random pix_valid gaps -> output order and count match input, no lost beats.

Source files
------------

// File: rtl/unsharp_mask_stage.sv
// rtl/unsharp_mask_stage.sv - unsharp-mask sharpening of aligned original/blurred pixel pairs
// Optional UNSHARP_CORING_EN adds a per-channel coring threshold input.
module unsharp_mask_stage #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int RADIUS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        sof,
  input  logic [23:0] pix_orig,
  input  logic [23:0] pix_blur,
  input  logic [3:0]  amount,
`ifdef UNSHARP_CORING_EN
  input  logic [7:0]  coring,
`endif
  output logic [23:0] pix_out,
  output logic        out_valid,
  output logic        out_border
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic          sof_beat;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [3:0]    amount_q, amount_d;
  logic          cur_border;

  logic          v1_q, v2_q, border1_q, border2_q;
  logic [23:0]   orig1_q, orig2_q;
  logic [3:0]    amt1_q;
  logic [23:0]   res_w;
  logic [23:0]   pix_out_q;
  logic          out_valid_q, out_border_q;

  // The sof beat itself is position (0,0) and already uses the newly latched gain.
  assign sof_beat   = pix_valid & sof;
  assign cur_col    = sof_beat ? '0 : col_q;
  assign cur_row    = sof_beat ? '0 : row_q;
  assign amount_d   = sof_beat ? amount : amount_q;
  assign cur_border = (cur_col <  CW'(RADIUS))
                    | (cur_col >= CW'(WIDTH - RADIUS))
                    | (cur_row <  RW'(RADIUS))
                    | (cur_row >= RW'(HEIGHT - RADIUS));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pix_valid) begin
      if (cur_col == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      amount_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      amount_q <= amount_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      border1_q <= 1'b0;
      border2_q <= 1'b0;
      orig1_q   <= '0;
      orig2_q   <= '0;
      amt1_q    <= '0;
    end else begin
      v1_q <= pix_valid;
      v2_q <= v1_q;
      if (pix_valid) begin
        border1_q <= cur_border;
        orig1_q   <= pix_orig;
        amt1_q    <= amount_d;
      end
      if (v1_q) begin
        border2_q <= border1_q;
        orig2_q   <= orig1_q;
      end
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic signed [8:0]  d_w, d1_q;
    logic signed [13:0] p_w;
    logic signed [11:0] s_w, s2_q, t_w;
`ifdef UNSHARP_CORING_EN
    logic [8:0]         mag_w;
`endif

    always_comb begin
      d_w = $signed({1'b0, pix_orig[8*c +: 8]}) - $signed({1'b0, pix_blur[8*c +: 8]});
`ifdef UNSHARP_CORING_EN
      mag_w = d_w[8] ? $unsigned(-d_w) : $unsigned(d_w);
      if (mag_w < {1'b0, coring}) begin
        d_w = '0;
      end
`endif
    end

    // Gain is unsigned Q2.2, so the >>>2 floors the product back to integer pixel units.
    assign p_w = 14'(d1_q) * $signed(14'({1'b0, amt1_q}));
    assign s_w = 12'(p_w >>> 2);
    assign t_w = $signed({4'b0000, orig2_q[8*c +: 8]}) + s2_q;

    assign res_w[8*c +: 8] = border2_q          ? orig2_q[8*c +: 8] :
                             t_w[11]            ? 8'h00 :
                             (t_w > 12'sd255)   ? 8'hFF : t_w[7:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d1_q <= '0;
        s2_q <= '0;
      end else begin
        if (pix_valid) begin
          d1_q <= d_w;
        end
        if (v1_q) begin
          s2_q <= s_w;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_out_q    <= '0;
      out_valid_q  <= 1'b0;
      out_border_q <= 1'b0;
    end else begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        pix_out_q    <= res_w;
        out_border_q <= border2_q;
      end
    end
  end

  assign pix_out    = pix_out_q;
  assign out_valid  = out_valid_q;
  assign out_border = out_border_q;

endmodule

// File: tb/tb_unsharp_mask_stage.sv
// tb/tb_unsharp_mask_stage.sv - randomized bench for unsharp_mask_stage against a frame-level model
// Compile with UNSHARP_CORING_EN to also exercise the coring threshold.
module tb_unsharp_mask_stage;
  localparam int W = 32;
  localparam int H = 20;
  localparam int R = 5;

  logic        clk = 1'b0;
  logic        rst, pix_valid, sof;
  logic [23:0] pix_orig, pix_blur;
  logic [3:0]  amount;
`ifdef UNSHARP_CORING_EN
  logic [7:0]  coring;
`endif
  logic [23:0] pix_out;
  logic        out_valid, out_border;

  int          total = 0;
  int          passed = 0;
  int          next_pos = 0;
  logic [3:0]  frame_amt = 4'd0;
  logic        exp_v [1:3];
  logic [23:0] exp_p [1:3];
  logic        exp_b [1:3];
  logic [23:0] last_pix = 24'd0;
  int          border_cnt = 0;

  always #5 clk = ~clk;

  unsharp_mask_stage #(.WIDTH(W), .HEIGHT(H), .RADIUS(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_valid (pix_valid),
    .sof       (sof),
    .pix_orig  (pix_orig),
    .pix_blur  (pix_blur),
    .amount    (amount),
`ifdef UNSHARP_CORING_EN
    .coring    (coring),
`endif
    .pix_out   (pix_out),
    .out_valid (out_valid),
    .out_border(out_border)
  );

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit is_border(input int pos);
    int col, row;
    col = pos % W;
    row = pos / W;
    return (col < R) || (col >= W - R) || (row < R) || (row >= H - R);
  endfunction

  function automatic logic [23:0] sharpen(input logic [23:0] o, input logic [23:0] b, input logic [3:0] a);
    logic [23:0] r;
    int oi, bi, d, p, s, t;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      oi = int'(o[8*c +: 8]);
      bi = int'(b[8*c +: 8]);
      d  = oi - bi;
`ifdef UNSHARP_CORING_EN
      if (((d < 0) ? -d : d) < int'(coring)) d = 0;
`endif
      p = d * int'(a);
      s = (p >= 0) ? p / 4 : -((-p + 3) / 4);
      t = oi + s;
      if (t < 0) t = 0;
      if (t > 255) t = 255;
      r[8*c +: 8] = 8'(t);
    end
    return r;
  endfunction

  task automatic step(input logic v, input logic s, input logic [23:0] o, input logic [23:0] b,
                      input logic [3:0] a);
    int          pos;
    logic        nv;
    logic [23:0] np;
    logic        nb;
    nv = 1'b0;
    np = '0;
    nb = 1'b0;
    pix_valid = v;
    sof       = s;
    pix_orig  = o;
    pix_blur  = b;
    amount    = a;
    if (v) begin
      if (s) begin
        pos       = 0;
        frame_amt = a;
      end else begin
        pos = next_pos;
      end
      next_pos = (pos + 1) % (W * H);
      nb = is_border(pos);
      np = nb ? o : sharpen(o, b, frame_amt);
      nv = 1'b1;
    end
    @(posedge clk);
    #1;
    for (int k = 3; k > 1; k--) begin
      exp_v[k] = exp_v[k-1];
      exp_p[k] = exp_p[k-1];
      exp_b[k] = exp_b[k-1];
    end
    exp_v[1] = nv;
    exp_p[1] = np;
    exp_b[1] = nb;
    chk("out_valid", 24'(out_valid), 24'(exp_v[3]));
    if (exp_v[3]) begin
      chk("pix_out", pix_out, exp_p[3]);
      chk("out_border", 24'(out_border), 24'(exp_b[3]));
      last_pix = exp_p[3];
      if (out_border) border_cnt++;
    end else begin
      chk("pix_hold", pix_out, last_pix);
    end
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic rnd_beat(input logic s, input logic [3:0] a);
    while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 24'($urandom), 24'($urandom), a);
    step(1'b1, s, 24'($urandom), 24'($urandom), a);
  endtask

  task automatic goto_interior(input logic [3:0] a);
    while (is_border(next_pos)) rnd_beat(1'b0, a);
  endtask

  task automatic flush();
    repeat (3) step(1'b0, 1'b0, 24'd0, 24'd0, 4'd0);
  endtask

  task automatic check_one(input string tag, input logic [23:0] o, input logic [23:0] b,
                           input logic [3:0] a, input logic [23:0] want);
    step(1'b1, 1'b0, o, b, a);
    step(1'b0, 1'b0, 24'd0, 24'd0, a);
    step(1'b0, 1'b0, 24'd0, 24'd0, a);
    chk({tag, "_valid"}, 24'(out_valid), 24'd1);
    chk(tag, pix_out, want);
    chk({tag, "_border"}, 24'(out_border), 24'd0);
  endtask

  task automatic clear_model();
    for (int k = 1; k <= 3; k++) begin
      exp_v[k] = 1'b0;
      exp_p[k] = '0;
      exp_b[k] = 1'b0;
    end
    last_pix  = '0;
    next_pos  = 0;
    frame_amt = 4'd0;
  endtask

  initial begin
    rst       = 1'b1;
    pix_valid = 1'b0;
    sof       = 1'b0;
    pix_orig  = '0;
    pix_blur  = '0;
    amount    = '0;
`ifdef UNSHARP_CORING_EN
    coring    = 8'd16;
`endif
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pix", pix_out, 24'd0);
    chk("reset_valid", 24'(out_valid), 24'd0);
    chk("reset_border", 24'(out_border), 24'd0);
    rst = 1'b0;

    // No sof yet: gain register is still zero, so every pixel passes unchanged.
    repeat (200) rnd_beat(1'b0, 4'hF);

    rnd_beat(1'b1, 4'd4);
    goto_interior(4'd4);
    check_one("gain1", 24'h808080, 24'h707070, 4'd4, 24'h909090);

    goto_interior(4'd8);
    check_one("gain_hold", 24'h808080, 24'h707070, 4'd8, 24'h909090);
    rnd_beat(1'b1, 4'd8);
    goto_interior(4'd8);
    check_one("gain2", 24'h808080, 24'h707070, 4'd8, 24'hA0A0A0);

    rnd_beat(1'b1, 4'd15);
    goto_interior(4'd15);
    check_one("clamp", 24'hF0F010, 24'h10F0F0, 4'd15, 24'hFFF000);

`ifdef UNSHARP_CORING_EN
    rnd_beat(1'b1, 4'd4);
    goto_interior(4'd4);
    check_one("core_small", 24'h808080, 24'h767676, 4'd4, 24'h808080);
    check_one("core_big", 24'h808080, 24'h6C6C6C, 4'd4, 24'h949494);
`endif

    // Reset while beats are in flight.
    repeat (3) step(1'b1, 1'b0, 24'($urandom), 24'($urandom), 4'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 24'(out_valid), 24'd0);
    chk("midrst_pix", pix_out, 24'd0);
    chk("midrst_border", 24'(out_border), 24'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    repeat (4) step(1'b0, 1'b0, 24'd0, 24'd0, 4'd0);
    repeat (20) rnd_beat(1'b0, 4'd7);
    flush();

    // Full frame with random data and gaps; count border-flagged outputs.
    border_cnt = 0;
    rnd_beat(1'b1, 4'($urandom_range(1, 15)));
    for (int i = 1; i < W * H; i++) rnd_beat(1'b0, 4'($urandom));
    flush();
    chk("border_count", 24'(border_cnt), 24'(W * H - (W - 2 * R) * (H - 2 * R)));

    // Random mid-frame sof resynchronisation with random gains.
    repeat (600) rnd_beat($urandom_range(0, 60) == 0, 4'($urandom));
    flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
